// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues icache reads, parks a word while decode stalls.
// Optional FETCH_PERF_EN adds saturating fetch/stall performance counters.
//
// state  | meaning
// FETCH  | read request to icache at pc, forward the hit to IF/ID
// HOLD   | decode stalled on a returned word; present it from the hold buffer
// HALTED | halt seen; no further fetching until reset
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        halt_i,
   input  logic        ihit,
   input  logic [31:0] imemload,
   output logic        imemREN,
   output logic [31:0] imemaddr,
   output logic [31:0] instr_o,
   output logic [31:0] npc_o,
   output logic [31:0] curr_pc_o,
   output logic        ifid_en_o,
`ifdef FETCH_PERF_EN
   output logic        ifid_flush_o,
   output logic [31:0] fetch_count_o,
   output logic [31:0] stall_count_o
`else
   output logic        ifid_flush_o
`endif
);

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      HOLD   = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] pc;
   logic [31:0] pc_next;
   logic [31:0] buf_instr;
   logic [31:0] buf_instr_next;
   logic [31:0] buf_pc;
   logic [31:0] buf_pc_next;
   logic [31:0] pc_inc;
   logic [31:0] buf_pc_inc;

   assign pc_inc     = pc + PC_STEP;
   assign buf_pc_inc = buf_pc + PC_STEP;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= FETCH;
         pc        <= RESET_PC;
         buf_instr <= 32'h0;
         buf_pc    <= 32'h0;
      end else begin
         state     <= state_next;
         pc        <= pc_next;
         buf_instr <= buf_instr_next;
         buf_pc    <= buf_pc_next;
      end
   end

   always_comb begin
      state_next     = state;
      pc_next        = pc;
      buf_instr_next = buf_instr;
      buf_pc_next    = buf_pc;
      case (state)
         FETCH: begin
            if (redirect_i) begin
               pc_next        = redirect_pc_i;
               buf_instr_next = 32'h0;
               buf_pc_next    = 32'h0;
               state_next     = FETCH;
            end else if (halt_i) begin
               state_next = HALTED;
            end else if (ihit) begin
               pc_next = pc_inc;
               if (stall_i) begin
                  buf_instr_next = imemload;
                  buf_pc_next    = pc;
                  state_next     = HOLD;
               end
            end
         end
         HOLD: begin
            if (redirect_i) begin
               pc_next        = redirect_pc_i;
               buf_instr_next = 32'h0;
               buf_pc_next    = 32'h0;
               state_next     = FETCH;
            end else if (halt_i) begin
               buf_instr_next = 32'h0;
               buf_pc_next    = 32'h0;
               state_next     = HALTED;
            end else if (!stall_i) begin
               state_next = FETCH;
            end
         end
         HALTED: begin
            state_next = HALTED;
         end
         default: begin
            state_next = FETCH;
         end
      endcase
   end

   // Reset forces every output low, regardless of state or icache activity.
   always_comb begin
      imemREN      = 1'b0;
      imemaddr     = 32'h0;
      instr_o      = 32'h0;
      npc_o        = 32'h0;
      curr_pc_o    = 32'h0;
      ifid_en_o    = 1'b0;
      ifid_flush_o = 1'b0;
      if (!RST) begin
         case (state)
            FETCH: begin
               imemaddr  = pc;
               instr_o   = imemload;
               curr_pc_o = pc;
               npc_o     = pc_inc;
               if (redirect_i) begin
                  ifid_flush_o = 1'b1;
               end else if (!halt_i) begin
                  imemREN   = 1'b1;
                  ifid_en_o = ihit & ~stall_i;
               end
            end
            HOLD: begin
               imemaddr  = pc;
               instr_o   = buf_instr;
               curr_pc_o = buf_pc;
               npc_o     = buf_pc_inc;
               if (redirect_i) begin
                  ifid_flush_o = 1'b1;
               end else if (!halt_i) begin
                  ifid_en_o = ~stall_i;
               end
            end
            HALTED: begin
               imemaddr  = pc;
               curr_pc_o = pc;
               npc_o     = pc_inc;
            end
            default: begin
               imemaddr = pc;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   logic stall_event;

   assign stall_event = (imemREN & ~ihit) | ((state == HOLD) & stall_i);

   always_ff @(posedge CLK) begin
      if (RST) begin
         fetch_count_o <= 32'h0;
         stall_count_o <= 32'h0;
      end else begin
         if (ifid_en_o && (fetch_count_o != 32'hFFFF_FFFF))
            fetch_count_o <= fetch_count_o + 32'd1;
         if (stall_event && (stall_count_o != 32'hFFFF_FFFF))
            stall_count_o <= stall_count_o + 32'd1;
      end
   end
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage. Produces the write side of the IF/ID pipeline latch: instr/npc/curr_pc data plus the latch enable and flush strobes.
- Owns the PC register and issues word reads to the instruction cache. It waits on ihit.
- Parks one returned instruction in a hold buffer while decode stalls.
- Redirects on a branch or jump resolved downstream. Stops fetching on halt.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment to the next sequential instruction.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- stall_i  input  1  hazard unit: IF/ID must not advance this cycle.
- redirect_i  input  1  taken branch/jump resolved downstream; current fetch is wrong-path.
- redirect_pc_i  input  32  target PC accompanying redirect_i.
- halt_i  input  1  halt decoded downstream; cease fetching.
- ihit  input  1  icache returns valid data this cycle.
- imemload  input  32  icache read data.
- imemREN  output  1  icache read request.
- imemaddr  output  32  icache read address.
- instr_o  output  32  to IF/ID instr_i.
- npc_o  output  32  to IF/ID npc_i.
- curr_pc_o  output  32  to IF/ID curr_pc_i.
- ifid_en_o  output  1  to IF/ID en.
- ifid_flush_o  output  1  to IF/ID flush.

Behaviour:
- Registered state: pc (32), hold buffer (instr, pc; 32 bits each), FSM state.
- Reset (RST=1 at a rising edge): pc=RESET_PC, buffer cleared, state=FETCH.
- While RST=1, all outputs are driven 0: imemREN, imemaddr, instr_o, npc_o, curr_pc_o, ifid_en_o, ifid_flush_o.
- Reset mid-request abandons the request. Any ihit arriving during reset is ignored.
- FSM states: FETCH, HOLD, HALTED.
- Event priority within a cycle: RST > redirect_i > halt_i > ihit/stall handling.
- FETCH outputs:
  - imemREN=1, imemaddr=pc.
  - instr_o=imemload, curr_pc_o=pc, npc_o=pc+PC_STEP. The addition is modulo 2^32 (wraps to 0).
- FETCH transitions:
  - ihit=0: ifid_en_o=0; pc holds; stay FETCH. Cache miss latency is unbounded.
  - ihit=1, stall_i=0: ifid_en_o=1 (single-cycle latency, request to latch); pc <= pc+PC_STEP; stay FETCH.
  - ihit=1, stall_i=1: ifid_en_o=0; buffer <= {imemload, pc}; pc <= pc+PC_STEP; go to HOLD.
- HOLD:
  - imemREN=0. instr_o/curr_pc_o come from the buffer; npc_o = buffered pc+PC_STEP.
  - ifid_en_o = !stall_i. On !stall_i, go to FETCH on the next cycle (no bubble beyond the stall).
- HALTED:
  - imemREN=0, ifid_en_o=0, ifid_flush_o=0.
  - Exit only via RST. redirect_i is ignored once HALTED.
- redirect_i=1 in FETCH or HOLD:
  - ifid_flush_o=1, ifid_en_o=0, imemREN=0.
  - pc <= redirect_pc_i; buffer invalidated; any concurrent ihit discarded; next state FETCH.
  - stall_i is ignored for that cycle.
- halt_i=1 (no redirect) in FETCH or HOLD:
  - ifid_en_o=0, imemREN=0; next state HALTED.
  - A buffered instruction is dropped.
  - redirect_i together with halt_i: redirect wins (the halt was wrong-path).
- Invariants:
  - ifid_en_o and ifid_flush_o are never both 1.
  - imemREN=0 whenever state != FETCH.
  - imemaddr is always word-aligned only if RESET_PC and redirect targets are aligned; no alignment check is performed.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds output ports fetch_count_o (32) and stall_count_o (32), both reset to 0 by RST.
  - fetch_count_o increments on every cycle with ifid_en_o=1.
  - stall_count_o increments on every cycle with imemREN=1 && ihit=0, or state==HOLD && stall_i=1.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then ihit=1 every cycle, imemload=32'h0000_1111, stall_i=0 -> imemaddr sequence 0,4,8; ifid_en_o=1 each cycle; curr_pc_o/npc_o = 0/4, 4/8, 8/12.
- ihit=1 at pc=8 with stall_i=1 held 3 cycles -> HOLD, imemREN=0; instr_o holds the captured word; ifid_en_o=0 for 3 cycles, then 1 with curr_pc_o=8; next imemaddr=12.
- redirect_i=1, redirect_pc_i=32'h0000_0400, concurrent ihit=1 -> ifid_flush_o=1, ifid_en_o=0; next cycle imemaddr=32'h400.
- Redirect during HOLD -> buffer discarded, flush pulse, fetch resumes at target; the buffered instruction never reaches the latch.
- halt_i=1 with redirect_i=0 -> HALTED; imemREN=0 and ifid_en_o=0 for 10+ cycles regardless of ihit/redirect_i; RST=1 -> imemaddr=RESET_PC.
- RESET_PC=32'hFFFF_FFFC, ihit=1 -> npc_o=0, next imemaddr=0 (wrap).
